// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, I-cache request handshake and ID pipeline register.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag (misaligned_o).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, no request; moves to FETCH next cycle
// FETCH | request at pc_q outstanding, one word per cycle on hits
// HOLD  | word captured while ID stalled; no request outstanding
// FLUSH | redirected while request outstanding; drain then jump
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        next_pc_sel_i,
    input  logic [31:0] redirect_target_i,
    input  logic        pc_stall_i,
    input  logic        id_stall_i,
    output logic        icache_valid_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ready_i,
    input  logic [31:0] icache_rd_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_o
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pending_q;
    logic [31:0] hold_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        unused_target_lsbs;

    // Redirects always land word-aligned; the low bits only feed the optional flag.
    assign target             = {redirect_target_i[31:2], 2'b00};
    assign unused_target_lsbs = |redirect_target_i[1:0];
    assign pc_plus4           = pc_q + 32'd4;

    // FLUSH keeps the original request on the bus until the cache answers.
    assign icache_valid_o = (state_q == FETCH) || (state_q == FLUSH);
    assign icache_addr_o  = pc_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pending_q  <= 32'd0;
            hold_q     <= 32'd0;
            id_pc_o    <= 32'd0;
            id_instr_o <= 32'd0;
            id_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_pc_sel_i) begin
                        pc_q <= target;
                    end
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (next_pc_sel_i) begin
                        id_valid_o <= 1'b0;
                        if (icache_ready_i) begin
                            pc_q <= target;
                        end else begin
                            pending_q <= target;
                            state_q   <= FLUSH;
                        end
                    end else if (icache_ready_i) begin
                        if (!id_stall_i) begin
                            id_pc_o    <= pc_q;
                            id_instr_o <= icache_rd_data_i;
                            id_valid_o <= 1'b1;
                            if (!pc_stall_i) begin
                                pc_q <= pc_plus4;
                            end
                        end else begin
                            hold_q  <= icache_rd_data_i;
                            state_q <= HOLD;
                        end
                    end else if (!id_stall_i) begin
                        id_valid_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (next_pc_sel_i) begin
                        pc_q       <= target;
                        id_valid_o <= 1'b0;
                        state_q    <= FETCH;
                    end else if (!id_stall_i) begin
                        id_pc_o    <= pc_q;
                        id_instr_o <= hold_q;
                        id_valid_o <= 1'b1;
                        if (!pc_stall_i) begin
                            pc_q <= pc_plus4;
                        end
                        state_q <= FETCH;
                    end
                end
                FLUSH: begin
                    id_valid_o <= 1'b0;
                    // A redirect arriving with the drain response is the newest target.
                    if (icache_ready_i) begin
                        pc_q    <= next_pc_sel_i ? target : pending_q;
                        state_q <= FETCH;
                    end else if (next_pc_sel_i) begin
                        pending_q <= target;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            misaligned_o <= 1'b0;
        end else if (next_pc_sel_i && unused_target_lsbs) begin
            misaligned_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; the cache model returns address ^ MAGIC as the instruction.
// Define FETCH_MISALIGN_CHECK_EN to also exercise the misaligned-redirect flag.
module tb_fetch_stage;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        next_pc_sel;
    logic [31:0] redirect_target;
    logic        pc_stall;
    logic        id_stall;
    logic        icache_valid;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_rd_data;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .next_pc_sel_i     (next_pc_sel),
        .redirect_target_i (redirect_target),
        .pc_stall_i        (pc_stall),
        .id_stall_i        (id_stall),
        .icache_valid_o    (icache_valid),
        .icache_addr_o     (icache_addr),
        .icache_ready_i    (icache_ready),
        .icache_rd_data_i  (icache_rd_data),
        .id_pc_o           (id_pc),
        .id_instr_o        (id_instr),
        .id_valid_o        (id_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned_o      (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign icache_rd_data = icache_addr ^ MAGIC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one delivered instruction in the ID register plus the next fetch address.
    task automatic chk_deliver(input string tag, input logic [31:0] pc, input logic [31:0] nxt);
        chk({tag, "_idv"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_idpc"}, id_pc, pc);
        chk({tag, "_instr"}, id_instr, pc ^ MAGIC);
        chk({tag, "_addr"}, icache_addr, nxt);
    endtask

    initial begin
        reset = 1'b0; next_pc_sel = 1'b0; redirect_target = 32'd0;
        pc_stall = 1'b0; id_stall = 1'b0; icache_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, icache_valid}, 32'd0);
        chk("rst_idv", {31'd0, id_valid}, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        chk("rst_instr", id_instr, 32'd0);

        // Streaming hits after reset release
        reset = 1'b1; icache_ready = 1'b1;
        tick();
        chk("rel_valid", {31'd0, icache_valid}, 32'd1);
        chk("rel_addr", icache_addr, 32'h0);
        chk("rel_idv", {31'd0, id_valid}, 32'd0);
        tick();
        chk_deliver("hit0", 32'h0, 32'h4);
        tick();
        chk_deliver("hit4", 32'h4, 32'h8);
        tick();
        chk_deliver("hit8", 32'h8, 32'hC);
        tick();
        chk_deliver("hitc", 32'hC, 32'h10);

        // Miss held three cycles at 0x10
        icache_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("miss_addr", icache_addr, 32'h10);
            chk("miss_valid", {31'd0, icache_valid}, 32'd1);
            chk("miss_idv", {31'd0, id_valid}, 32'd0);
        end
        icache_ready = 1'b1;
        tick();
        chk_deliver("miss_done", 32'h10, 32'h14);

        // ID stall while response for 0x14 arrives
        id_stall = 1'b1;
        tick();
        chk("hold_valid", {31'd0, icache_valid}, 32'd0);
        chk("hold_idpc", id_pc, 32'h10);
        chk("hold_idv", {31'd0, id_valid}, 32'd1);
        icache_ready = 1'b0;
        tick();
        chk("hold2_valid", {31'd0, icache_valid}, 32'd0);
        chk("hold2_idpc", id_pc, 32'h10);
        id_stall = 1'b0;
        tick();
        chk_deliver("hold_rel", 32'h14, 32'h18);
        icache_ready = 1'b1;
        tick();
        chk_deliver("post_hold18", 32'h18, 32'h1C);
        tick();
        chk_deliver("post_hold1c", 32'h1C, 32'h20);

        // Redirect to 0x200 while 0x20 outstanding
        icache_ready = 1'b0;
        tick();
        chk("pre_fl_addr", icache_addr, 32'h20);
        next_pc_sel = 1'b1; redirect_target = 32'h200;
        tick();
        chk("fl_valid", {31'd0, icache_valid}, 32'd1);
        chk("fl_addr", icache_addr, 32'h20);
        chk("fl_idv", {31'd0, id_valid}, 32'd0);
        next_pc_sel = 1'b0; redirect_target = 32'h0;
        id_stall = 1'b1;
        tick();
        chk("fl2_addr", icache_addr, 32'h20);
        id_stall = 1'b0; icache_ready = 1'b1;
        tick();
        chk("fl_done_addr", icache_addr, 32'h200);
        chk("fl_done_idv", {31'd0, id_valid}, 32'd0);
        icache_ready = 1'b0;
        tick();
        chk("post_fl_idv", {31'd0, id_valid}, 32'd0);
        icache_ready = 1'b1;
        tick();
        chk_deliver("tgt200", 32'h200, 32'h204);

        // Redirect coinciding with a hit; low target bits dropped
        next_pc_sel = 1'b1; redirect_target = 32'h303;
        tick();
        chk("rd_hit_addr", icache_addr, 32'h300);
        chk("rd_hit_idv", {31'd0, id_valid}, 32'd0);
        next_pc_sel = 1'b0;
        tick();
        chk_deliver("tgt300", 32'h300, 32'h304);

        // PC wrap
        next_pc_sel = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", icache_addr, 32'hFFFF_FFFC);
        next_pc_sel = 1'b0;
        tick();
        chk_deliver("wrap", 32'hFFFF_FFFC, 32'h0);

        // Reset during an outstanding request; late response ignored
        icache_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, icache_valid}, 32'd0);
        chk("mid_rst_idv", {31'd0, id_valid}, 32'd0);
        reset = 1'b1; icache_ready = 1'b1;
        tick();
        chk("late_idv", {31'd0, id_valid}, 32'd0);
        chk("late_addr", icache_addr, 32'h0);
        chk("late_valid", {31'd0, icache_valid}, 32'd1);
        tick();
        chk_deliver("after_rst", 32'h0, 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        next_pc_sel = 1'b1; redirect_target = 32'h102;
        tick();
        chk("mis_addr", icache_addr, 32'h100);
        chk("mis_set", {31'd0, misaligned}, 32'd1);
        next_pc_sel = 1'b0;
        tick();
        chk("mis_sticky", {31'd0, misaligned}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mis_rst", {31'd0, misaligned}, 32'd0);
        reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
